// File: rtl/fp_unpack_sequencer.sv
// rtl/fp_unpack_sequencer.sv - operand unpack sequencer sharing one combinational unpacker

// Combinational IEEE unpacker: splits double or single operands into a 126-bit bundle
// {s, e, f, lz, e_inf, e_z, fz, h}; singles are left-aligned into the double-width fields.
module unpackermaster (
    input  logic [63:0]  fp,
    input  logic         db,
    input  logic         normal,
    output logic [125:0] unp
);
    logic        s;
    logic [10:0] e;
    logic [51:0] h;
    logic        e_inf;
    logic        e_z;
    logic        fz;
    logic [52:0] sig;
    logic [52:0] f;
    logic [5:0]  lz;

    // Field extraction; the hidden bit is set for any non-zero exponent
    always_comb begin
        if (db) begin
            s     = fp[63];
            e     = fp[62:52];
            h     = fp[51:0];
            e_inf = &fp[62:52];
            e_z   = ~|fp[62:52];
        end else begin
            s     = fp[31];
            e     = {3'b000, fp[30:23]};
            h     = {fp[22:0], 29'b0};
            e_inf = &fp[30:23];
            e_z   = ~|fp[30:23];
        end
        fz  = ~|h;
        sig = {~e_z, h};
    end

    // Leading-zero count of the significand; 53 when the significand is zero.
    // Ascending scan so the most significant set bit assigns last.
    always_comb begin
        lz = 6'd53;
        for (int i = 0; i < 53; i++) begin
            if (sig[i]) begin
                lz = 6'(52 - i);
            end
        end
    end

    // In normal mode subnormal significands come out left-justified
    always_comb begin
        f   = normal ? (sig << lz) : sig;
        unp = {s, e, f, lz, e_inf, e_z, fz, h};
    end
endmodule

module fp_unpack_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_fa,
    input  logic [63:0]      in_fb,
    input  logic             in_db,
    input  logic             in_normal,
    input  logic             in_unary,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [125:0]     out_a,
    output logic [125:0]     out_b,
    output logic             out_db,
    output logic             out_unary,
    output logic             out_special,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);
    localparam int UW = 126;
    // Bit positions of the special-value flags inside a bundle
    localparam int E_INF_BIT = 54;
    localparam int E_Z_BIT   = 53;

    typedef enum logic [1:0] {IDLE, UNPK_A, UNPK_B, HOLD} state_t;

    state_t        state;
    logic [63:0]   cap_fa;
    logic [63:0]   cap_fb;
    logic          cap_db;
    logic          cap_normal;
    logic          cap_unary;
    logic [63:0]   unp_fp;
    logic [UW-1:0] unp;
    logic          unp_special;
    logic          accept;

    // Feed the shared unpacker with whichever operand the current phase needs
    always_comb begin
        unique case (state)
            UNPK_A:  unp_fp = cap_fa;
            UNPK_B:  unp_fp = cap_fb;
            default: unp_fp = 64'd0;
        endcase
    end

    unpackermaster u_unpack (
        .fp     (unp_fp),
        .db     (cap_db),
        .normal (cap_normal),
        .unp    (unp)
    );

    // Handshake decode; a HOLD slot frees up in the same cycle the pair leaves
    always_comb begin
        in_ready    = ~flush & ((state == IDLE) | ((state == HOLD) & out_ready));
        accept      = in_valid & in_ready;
        out_valid   = (state == HOLD);
        busy        = (state != IDLE);
        out_db      = cap_db;
        out_unary   = cap_unary;
        unp_special = unp[E_INF_BIT] | unp[E_Z_BIT];
    end

    // Sequencer: capture, unpack A, optionally unpack B, hold for downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cap_fa      <= '0;
            cap_fb      <= '0;
            cap_db      <= 1'b0;
            cap_normal  <= 1'b0;
            cap_unary   <= 1'b0;
            out_a       <= '0;
            out_b       <= '0;
            out_special <= 1'b0;
            done_cnt    <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            if (accept) begin
                cap_fa     <= in_fa;
                cap_fb     <= in_fb;
                cap_db     <= in_db;
                cap_normal <= in_normal;
                cap_unary  <= in_unary;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= UNPK_A;
                    end
                end
                UNPK_A: begin
                    out_a <= unp;
                    if (cap_unary) begin
                        out_b       <= '0;
                        out_special <= unp_special;
                        state       <= HOLD;
                    end else begin
                        state <= UNPK_B;
                    end
                end
                UNPK_B: begin
                    out_b       <= unp;
                    out_special <= out_a[E_INF_BIT] | out_a[E_Z_BIT] | unp_special;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        done_cnt <= done_cnt + 1'b1;
                        state    <= accept ? UNPK_A : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_unpack_sequencer.sv
// tb/tb_fp_unpack_sequencer.sv - scoreboard bench for fp_unpack_sequencer

module tb_fp_unpack_sequencer;
    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_fa;
    logic [63:0]  in_fb;
    logic         in_db;
    logic         in_normal;
    logic         in_unary;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [125:0] out_a;
    logic [125:0] out_b;
    logic         out_db;
    logic         out_unary;
    logic         out_special;
    logic         busy;
    logic [3:0]   done_cnt;

    typedef struct packed {
        logic [125:0] a;
        logic [125:0] b;
        logic         db;
        logic         unary;
        logic         special;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] exp_cnt;
    int         n_checks;
    int         n_errors;

    fp_unpack_sequencer #(.CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fa       (in_fa),
        .in_fb       (in_fb),
        .in_db       (in_db),
        .in_normal   (in_normal),
        .in_unary    (in_unary),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_db      (out_db),
        .out_unary   (out_unary),
        .out_special (out_special),
        .busy        (busy),
        .done_cnt    (done_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [125:0] got, input logic [125:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference unpacker: field split, leading-zero count by scanning down from the MSB
    function automatic logic [125:0] ref_unpack(input logic [63:0] fp, input logic db, input logic normal);
        logic        s, einf, ez, fz;
        logic [10:0] ex;
        logic [51:0] m;
        logic [52:0] sig;
        int          lz;
        if (db) begin
            s = fp[63]; ex = fp[62:52]; m = fp[51:0];
        end else begin
            s = fp[31]; ex = {3'b000, fp[30:23]}; m = {fp[22:0], 29'b0};
        end
        einf = db ? (ex == 11'h7FF) : (ex == 11'h0FF);
        ez   = (ex == 11'h000);
        fz   = (m == 52'd0);
        sig  = {!ez, m};
        lz   = 0;
        while (lz < 53 && sig[52-lz] == 1'b0) lz++;
        if (normal) sig = sig << lz;
        return {s, ex, sig, 6'(lz), einf, ez, fz, m};
    endfunction

    function automatic exp_t make_exp(input logic [63:0] fa, input logic [63:0] fb,
                                      input logic db, input logic normal, input logic unary);
        exp_t x;
        x.a       = ref_unpack(fa, db, normal);
        x.b       = unary ? 126'd0 : ref_unpack(fb, db, normal);
        x.db      = db;
        x.unary   = unary;
        x.special = x.a[54] | x.a[53] | (!unary & (x.b[54] | x.b[53]));
        return x;
    endfunction

    // Scoreboard: push on accept, pop and compare on out handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            exp_cnt <= 4'd0;
        end else if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_out", 126'(1), 126'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_out_a", out_a, e.a);
                    check("sb_out_b", out_b, e.b);
                    check("sb_out_db", 126'(out_db), 126'(e.db));
                    check("sb_out_unary", 126'(out_unary), 126'(e.unary));
                    check("sb_out_special", 126'(out_special), 126'(e.special));
                    check("sb_done_cnt", 126'(done_cnt), 126'(exp_cnt));
                    exp_cnt <= exp_cnt + 4'd1;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(make_exp(in_fa, in_fb, in_db, in_normal, in_unary));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start(input logic [63:0] fa, input logic [63:0] fb,
                         input logic db, input logic unary);
        in_fa = fa; in_fb = fb; in_db = db; in_normal = 1'b1; in_unary = unary;
        in_valid = 1'b1;
        #1;
        check("start_in_ready", 126'(in_ready), 126'(1));
        tick();
        in_valid = 1'b0;
        in_fb    = ~fb;
        in_db    = ~db;
        in_unary = ~unary;
    endtask

    initial begin
        exp_t ref_x;
        int   w;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_fa = '0; in_fb = '0; in_db = 1'b0;
        in_normal = 1'b0; in_unary = 1'b0; flush = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("rst_out_valid", 126'(out_valid), 126'(0));
        check("rst_busy", 126'(busy), 126'(0));
        check("rst_done_cnt", 126'(done_cnt), 126'(0));
        check("rst_in_ready", 126'(in_ready), 126'(1));
        check("rst_out_a", out_a, 126'(0));
        rst_n = 1'b1;
        tick();

        // Binary double pair, 1.0 and -1.0
        out_ready = 1'b1;
        start(64'h3FF0000000000000, 64'hBFF0000000000000, 1'b1, 1'b0);
        check("bin_lat_t0", 126'(out_valid), 126'(0));
        tick();
        check("bin_lat_t1", 126'(out_valid), 126'(0));
        tick();
        check("bin_lat_t2", 126'(out_valid), 126'(1));
        check("bin_a_s", 126'(out_a[125]), 126'(0));
        check("bin_a_e", 126'(out_a[124:114]), 126'(11'h3FF));
        check("bin_b_s", 126'(out_b[125]), 126'(1));
        check("bin_b_e", 126'(out_b[124:114]), 126'(11'h3FF));
        check("bin_special", 126'(out_special), 126'(0));
        tick();
        check("bin_done_cnt", 126'(done_cnt), 126'(1));
        check("bin_idle", 126'(out_valid), 126'(0));

        // Infinity and zero
        start(64'h7FF0000000000000, 64'h0, 1'b1, 1'b0);
        tick(); tick();
        check("spc_a_einf", 126'(out_a[54]), 126'(1));
        check("spc_b_ez", 126'(out_b[53]), 126'(1));
        check("spc_b_fz", 126'(out_b[52]), 126'(1));
        check("spc_special", 126'(out_special), 126'(1));
        tick();

        // Unary: B phase skipped, B bundle cleared
        start(64'h3FF0000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1);
        check("un_lat_t0", 126'(out_valid), 126'(0));
        tick();
        check("un_lat_t1", 126'(out_valid), 126'(1));
        check("un_out_b", out_b, 126'(0));
        check("un_out_unary", 126'(out_unary), 126'(1));
        tick();
        check("un_done_cnt", 126'(done_cnt), 126'(3));

        // Backpressure, then back-to-back accept on the handshake cycle
        out_ready = 1'b0;
        ref_x = make_exp(64'hC00921FB54442D18, 64'h0000000000000001, 1'b1, 1'b1, 1'b0);
        start(64'hC00921FB54442D18, 64'h0000000000000001, 1'b1, 1'b0);
        tick(); tick();
        in_valid = 1'b1;
        in_fa = 64'h40490FDB; in_fb = 64'h00000001; in_db = 1'b0; in_unary = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", 126'(out_valid), 126'(1));
            check("bp_in_ready", 126'(in_ready), 126'(0));
            check("bp_out_a", out_a, ref_x.a);
            check("bp_out_b", out_b, ref_x.b);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 126'(in_ready), 126'(1));
        tick();
        in_valid = 1'b0;
        check("b2b_done_cnt", 126'(done_cnt), 126'(4));
        check("b2b_busy", 126'(busy), 126'(1));
        tick(); tick();
        check("b2b_out_valid", 126'(out_valid), 126'(1));
        tick();
        check("b2b_done_cnt2", 126'(done_cnt), 126'(5));

        // Flush during UNPK_B
        start(64'h3FF8000000000000, 64'h4000000000000000, 1'b1, 1'b0);
        tick();
        flush = 1'b1;
        #1;
        check("flb_in_ready", 126'(in_ready), 126'(0));
        tick();
        flush = 1'b0;
        check("flb_busy", 126'(busy), 126'(0));
        check("flb_done_cnt", 126'(done_cnt), 126'(5));

        // Flush in HOLD with out_ready high and a competing request
        start(64'h3FF8000000000000, 64'h4000000000000000, 1'b1, 1'b0);
        tick(); tick();
        flush = 1'b1; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flh_busy", 126'(busy), 126'(0));
        check("flh_done_cnt", 126'(done_cnt), 126'(5));
        tick();
        check("flh_still_idle", 126'(out_valid), 126'(0));

        // Asynchronous reset during UNPK_A
        start(64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 126'(out_valid), 126'(0));
        check("ar_busy", 126'(busy), 126'(0));
        check("ar_done_cnt", 126'(done_cnt), 126'(0));
        check("ar_out_a", out_a, 126'(0));
        check("ar_out_b", out_b, 126'(0));
        check("ar_flags", 126'({out_special, out_db, out_unary}), 126'(0));
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 17 random pairs streamed back to back; 4-bit counter wraps to 1
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int n = 0; n < 17; n++) begin
            in_fa     = (n % 4 == 0) ? 64'h7FF0000000000000 : {$urandom, $urandom};
            in_fb     = (n % 5 == 0) ? 64'h0 : {$urandom, $urandom};
            in_db     = 1'($urandom_range(0, 1));
            in_normal = 1'($urandom_range(0, 1));
            in_unary  = (n % 3 == 2);
            w = 0;
            while (!in_ready && w < 10) begin
                tick();
                w++;
            end
            if (w >= 10) check("wrap_accept_timeout", 126'(1), 126'(0));
            tick();
        end
        in_valid = 1'b0;
        w = 0;
        while (busy && w < 10) begin
            tick();
            w++;
        end
        if (w >= 10) check("wrap_drain_timeout", 126'(1), 126'(0));
        tick();
        check("wrap_done_cnt", 126'(done_cnt), 126'(1));
        check("wrap_sb_empty", 126'(sb.size()), 126'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/fp_unpack_sequencer.md
Name: fp_unpack_sequencer

Overview:
- Front-end controller for the FPU operand path.
- Accepts an operand pair (or a single operand for unary ops) over a valid/ready handshake.
- Time-multiplexes one instance of the team's combinational unpacker, `unpackermaster`, across operand A, then operand B.
- Registers both unpacked bundles and presents them to the downstream datapath over a second valid/ready handshake, with summary special-value flags and a completion counter.

Parameters:
- CNT_W, 16, width of the completed-operation counter (wraps).
- UW, 126, unpacked bundle width. Local, not overridable. Field order MSB→LSB: s(1), e(11), f(53), lz(6), e_inf(1), e_z(1), fz(1), h(52).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  sequencer can accept a request this cycle.
- in_fa  in  64  operand A raw bits.
- in_fb  in  64  operand B raw bits; ignored when in_unary=1.
- in_db  in  1  1 = double, 0 = single; passed to the unpacker db.
- in_normal  in  1  passed to the unpacker normal.
- in_unary  in  1  1 = single-operand op, B phase skipped.
- flush  in  1  synchronous abort of the in-flight request.
- out_valid  out  1  unpacked pair available.
- out_ready  in  1  downstream accepts the pair.
- out_a  out  UW  unpacked operand A bundle.
- out_b  out  UW  unpacked operand B bundle; all-zero for unary.
- out_db  out  1  registered in_db of the current pair.
- out_unary  out  1  registered in_unary.
- out_special  out  1  e_inf|e_z of A, OR-ed with B's when not unary.
- busy  out  1  state != IDLE.
- done_cnt  out  CNT_W  number of completed out handshakes, mod 2^CNT_W.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; all operand/config registers, out_a, out_b, out_db, out_unary, out_special and done_cnt = 0; out_valid=0; busy=0. in_ready is combinational and equals 1 after reset.
- Single unpacker instance. Its fp input muxes: captured fa in UNPK_A, captured fb in UNPK_B, 0 otherwise. Its db and normal inputs come from the captured registers.
- States: IDLE, UNPK_A, UNPK_B, HOLD.
- in_ready = (state==IDLE) | (state==HOLD & out_ready); forced 0 when flush=1.
- Accept = in_valid & in_ready. On accept, capture fa, fb, db, normal and unary. Next state = UNPK_A.
- UNPK_A: capture the unpacker outputs into out_a.
  - If unary: out_b←0, then HOLD.
  - Else: go to UNPK_B.
- UNPK_B: capture unpacker outputs into out_b, then HOLD.
- out_special is registered on entry to HOLD.
- out_valid = (state==HOLD). All out_* fields stay stable while out_valid=1 and out_ready=0.
- HOLD with out_ready=1:
  - done_cnt increments, wrapping from all-ones to 0.
  - If in_valid=1, perform a back-to-back accept and go to UNPK_A.
  - Otherwise go to IDLE.
- HOLD with out_ready=0: remain in HOLD.
- Latency from the accept edge T: out_valid=1 after edge T+2 for binary ops, T+1 for unary ops.
- Throughput: one binary pair per 3 cycles with out_ready held high (2 unpack cycles + 1 HOLD/accept cycle); one unary op per 2 cycles.
- out_a/out_b update only in UNPK_A/UNPK_B; after out handshake they keep the previous values until overwritten.
- flush=1 at an edge, from any state: next state=IDLE, no accept that cycle, done_cnt unchanged. A pair in HOLD is dropped even if out_ready=1 that cycle; flush wins. out_a/out_b retain their contents.
- Reset asserted mid-operation clears everything asynchronously. No output is produced for the aborted request.
- in_fb, in_db, in_normal and in_unary changing after accept have no effect on the in-flight request.

Test Plan:
- Binary pair, double: fa=64'h3FF0000000000000, fb=64'hBFF0000000000000, db=1, normal=1, out_ready=1.
  - out_valid exactly 2 edges after accept.
  - out_a s=0, e=11'h3FF; out_b s=1, e=11'h3FF.
  - out_special=0; done_cnt=1.
- Specials: fa=64'h7FF0000000000000, fb=0, db=1.
  - out_a e_inf=1; out_b e_z=1, fz=1; out_special=1.
- Unary: in_unary=1, fa=64'h3FF0000000000000, fb=64'hFFFFFFFFFFFFFFFF.
  - out_valid 1 edge after accept; out_b all zeros; out_unary=1.
- Backpressure and back-to-back: hold out_ready=0 for 5 cycles.
  - out_a/out_b stable; in_ready=0 throughout.
  - Then out_ready=1 with in_valid=1: second request accepted in the same cycle as the handshake; done_cnt increments by exactly 1 per handshake.
- Flush/reset: flush in UNPK_B, and separately in HOLD with out_ready=1.
  - Returns to IDLE; no out handshake; done_cnt unchanged.
  - Deassert rst_n mid-UNPK_A: all outputs 0 immediately, before the next edge.
- Counter wrap: CNT_W=4, run 17 pairs → done_cnt=1.
